// File: rtl/pipe_hazard_pkg.sv
// Shared pipeline-control types: sequencer state encoding, control bundle
// and drain-length default.
package pipe_hazard_pkg;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SPLIT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_flush;
    logic slot0_kill;
    logic slot1_kill;
  } ctrl_t;

  // Freeze fetch and push a bubble into EX.
  function automatic ctrl_t ctrl_stall();
    ctrl_t c;
    c            = '0;
    c.pc_hold    = 1'b1;
    c.ifid_hold  = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Redirect: PC loads the target, younger instructions are squashed.
  function automatic ctrl_t ctrl_flush();
    ctrl_t c;
    c            = '0;
    c.ifid_flush = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer for the dual-issue pipe: hazard holds, split issue,
// redirect flushes and halt drain, plus stall/flush event counters.
module pipe_hazard_sequencer
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lu_hazard,
  input  logic             pair_conflict,
  input  logic             br_mispredict,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             slot0_kill,
  output logic             slot1_kill,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  seq_state_t    state, state_next;
  logic [DW-1:0] drain_cnt, drain_next;
  ctrl_t         ctrl_c;
  ctrl_t         ctrl;
  logic          inc_stall, inc_flush;

  // State, drain counter and halt acknowledge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      halt_ack  <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      halt_ack  <= (state_next == ST_HALTED);
    end
  end

  // Next state and same-cycle pipe controls; mispredict always wins.
  always_comb begin
    ctrl_c     = '0;
    state_next = state;
    drain_next = drain_cnt;
    inc_stall  = 1'b0;
    inc_flush  = 1'b0;
    case (state)
      ST_RUN: begin
        if (br_mispredict) begin
          ctrl_c    = ctrl_flush();
          inc_flush = 1'b1;
        end else if (lu_hazard) begin
          ctrl_c    = ctrl_stall();
          inc_stall = 1'b1;
        end else if (pair_conflict) begin
          ctrl_c.pc_hold    = 1'b1;
          ctrl_c.ifid_hold  = 1'b1;
          ctrl_c.slot1_kill = 1'b1;
          inc_stall         = 1'b1;
          state_next        = ST_SPLIT;
        end else if (halt_req) begin
          ctrl_c     = ctrl_stall();
          inc_stall  = 1'b1;
          drain_next = DRAIN_LOAD;
          state_next = ST_DRAIN;
        end
      end
      ST_SPLIT: begin
        if (br_mispredict) begin
          ctrl_c     = ctrl_flush();
          inc_flush  = 1'b1;
          state_next = ST_RUN;
        end else if (lu_hazard) begin
          ctrl_c    = ctrl_stall();
          inc_stall = 1'b1;
        end else begin
          ctrl_c.slot0_kill = 1'b1;
          state_next        = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (br_mispredict) begin
          ctrl_c     = ctrl_flush();
          inc_flush  = 1'b1;
          drain_next = DRAIN_LOAD;
          state_next = halt_req ? ST_DRAIN : ST_RUN;
        end else begin
          ctrl_c    = ctrl_stall();
          inc_stall = 1'b1;
          if (!halt_req) begin
            state_next = ST_RUN;
          end else if (drain_cnt == '0) begin
            state_next = ST_HALTED;
          end else begin
            drain_next = drain_cnt - DW'(1);
          end
        end
      end
      ST_HALTED: begin
        if (br_mispredict) begin
          ctrl_c    = ctrl_flush();
          inc_flush = 1'b1;
        end else begin
          ctrl_c    = ctrl_stall();
          inc_stall = 1'b1;
        end
        if (!halt_req) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Controls are forced low while reset is asserted.
  assign ctrl = reset ? ctrl_c : ctrl_t'('0);

  assign pc_hold    = ctrl.pc_hold;
  assign ifid_hold  = ctrl.ifid_hold;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign slot0_kill = ctrl.slot0_kill;
  assign slot1_kill = ctrl.slot1_kill;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_stall),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_flush),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Scoreboard bench for pipe_hazard_sequencer: per-cycle expectations are queued
// as stimulus is driven and compared mid-cycle against the DUT.
module tb_pipe_hazard_sequencer;

  localparam int unsigned CNT_W = 16;
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b110100;
  localparam logic [5:0] C_FLUSH = 6'b001100;
  localparam logic [5:0] C_SPLIT = 6'b110001;
  localparam logic [5:0] C_K0    = 6'b000010;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lu_hazard = 1'b0, pair_conflict = 1'b0, br_mispredict = 1'b0;
  logic halt_req = 1'b0, cnt_clr = 1'b0;
  logic pc_hold, ifid_hold, ifid_flush, idex_flush, slot0_kill, slot1_kill;
  logic halt_ack;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    logic [5:0] ctrl;
    logic       ha;
    int         s;
    int         f;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_no = 0;

  pipe_hazard_sequencer #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .lu_hazard     (lu_hazard),
    .pair_conflict (pair_conflict),
    .br_mispredict (br_mispredict),
    .halt_req      (halt_req),
    .cnt_clr       (cnt_clr),
    .pc_hold       (pc_hold),
    .ifid_hold     (ifid_hold),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .slot0_kill    (slot0_kill),
    .slot1_kill    (slot1_kill),
    .halt_ack      (halt_ack),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc_no, obs, exp);
    end
  endtask

  function automatic logic [5:0] ctrl_now();
    return {pc_hold, ifid_hold, ifid_flush, idex_flush, slot0_kill, slot1_kill};
  endfunction

  // One cycle: inputs {lu, pair, mispredict, halt, clr}, expected outputs for that cycle.
  task automatic cyc(input logic [4:0] in, input logic [5:0] ctrl, input logic ha,
                     input int s, input int f);
    exp_t e;
    @(posedge clk);
    #1;
    {lu_hazard, pair_conflict, br_mispredict, halt_req, cnt_clr} = in;
    e.ctrl = ctrl;
    e.ha   = ha;
    e.s    = s;
    e.f    = f;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cyc_no++;
      chk("ctrl", 32'(ctrl_now()), 32'(e.ctrl));
      chk("halt_ack", 32'(halt_ack), 32'(e.ha));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.s));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.f));
    end
  end

  initial begin
    // Controls stay low under reset even with a hazard present.
    @(posedge clk);
    #1;
    lu_hazard = 1'b1;
    #1;
    chk("rst_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("rst_halt_ack", 32'(halt_ack), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    lu_hazard = 1'b0;
    reset = 1'b1;

    // Idle
    for (int i = 0; i < 5; i++) cyc(5'b00000, C_IDLE, 1'b0, 0, 0);
    // Load-use stall
    cyc(5'b10000, C_STALL, 1'b0, 0, 0);
    cyc(5'b00000, C_IDLE,  1'b0, 1, 0);
    // Split issue
    cyc(5'b01000, C_SPLIT, 1'b0, 1, 0);
    cyc(5'b00000, C_K0,    1'b0, 2, 0);
    cyc(5'b00000, C_IDLE,  1'b0, 2, 0);
    // Mispredict beats load-use, then the stall follows
    cyc(5'b10100, C_FLUSH, 1'b0, 2, 0);
    cyc(5'b10000, C_STALL, 1'b0, 2, 1);
    cyc(5'b00000, C_IDLE,  1'b0, 3, 1);
    // Halt: request cycle, three drain cycles, halted, release
    cyc(5'b00010, C_STALL, 1'b0, 3, 1);
    cyc(5'b00010, C_STALL, 1'b0, 4, 1);
    cyc(5'b00010, C_STALL, 1'b0, 5, 1);
    cyc(5'b00010, C_STALL, 1'b0, 6, 1);
    cyc(5'b00010, C_STALL, 1'b1, 7, 1);
    cyc(5'b00010, C_STALL, 1'b1, 8, 1);
    cyc(5'b00000, C_STALL, 1'b1, 9, 1);
    cyc(5'b00000, C_IDLE,  1'b0, 10, 1);
    // Clear wins over a simultaneous increment
    cyc(5'b10001, C_STALL, 1'b0, 10, 1);
    cyc(5'b00000, C_IDLE,  1'b0, 0, 0);
    // Mispredict in second drain cycle restarts the drain
    cyc(5'b00010, C_STALL, 1'b0, 0, 0);
    cyc(5'b00010, C_STALL, 1'b0, 1, 0);
    cyc(5'b00110, C_FLUSH, 1'b0, 2, 0);
    cyc(5'b00010, C_STALL, 1'b0, 2, 1);
    cyc(5'b00010, C_STALL, 1'b0, 3, 1);
    cyc(5'b00010, C_STALL, 1'b0, 4, 1);
    cyc(5'b00010, C_STALL, 1'b1, 5, 1);
    cyc(5'b00010, C_STALL, 1'b1, 6, 1);

    // Asynchronous reset while halted
    @(posedge clk);
    #1;
    chk("halted_ctrl", 32'(ctrl_now()), 32'(C_STALL));
    #1;
    reset = 1'b0;
    #1;
    chk("async_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("async_halt_ack", 32'(halt_ack), 32'd0);
    chk("async_stall", 32'(stall_cnt), 32'd0);
    chk("async_flush", 32'(flush_cnt), 32'd0);
    halt_req = 1'b0;
    #1;
    reset = 1'b1;
    cyc(5'b00000, C_IDLE,  1'b0, 0, 0);

    // Load-use on slot1 during split, then mispredict during split
    cyc(5'b01000, C_SPLIT, 1'b0, 0, 0);
    cyc(5'b10000, C_STALL, 1'b0, 1, 0);
    cyc(5'b00000, C_K0,    1'b0, 2, 0);
    cyc(5'b00000, C_IDLE,  1'b0, 2, 0);
    cyc(5'b01000, C_SPLIT, 1'b0, 2, 0);
    cyc(5'b00100, C_FLUSH, 1'b0, 3, 0);
    cyc(5'b00000, C_IDLE,  1'b0, 3, 1);
    // Halt request dropped mid-drain returns to RUN without ack
    cyc(5'b00010, C_STALL, 1'b0, 3, 1);
    cyc(5'b00010, C_STALL, 1'b0, 4, 1);
    cyc(5'b00000, C_STALL, 1'b0, 5, 1);
    cyc(5'b00000, C_IDLE,  1'b0, 6, 1);
    cyc(5'b00000, C_IDLE,  1'b0, 6, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
Central stall/flush sequencer for the dual-issue 5-stage pipeline. It takes hazard, redirect and halt events and drives the hold/flush controls of the PC, the IF/ID register and the ID/EX register. It also sequences split issue of a dependent instruction pair and an orderly pipeline drain for halt/debug. Saturating stall and flush event counters are kept for performance tuning.

Parameters:
DRAIN_CYCLES, 3, bubble cycles inserted before halt_ack; covers instructions still in EX/MEM/WB.
CNT_W, 16, width of the stall and flush counters.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
lu_hazard  in  1  load-use hazard detected in ID, either slot
pair_conflict  in  1  slot1 depends on slot0 in the same ID pair
br_mispredict  in  1  EX-resolved branch/jump redirect; datapath loads target into PC this cycle
halt_req  in  1  level request to halt issue
cnt_clr  in  1  synchronous clear of both counters
pc_hold  out  1  freeze PC
ifid_hold  out  1  hold the IF/ID register
ifid_flush  out  1  zero the IF/ID register
idex_flush  out  1  zero the ID/EX register (bubble)
slot0_kill  out  1  replace slot0 with NOP at the ID/EX input
slot1_kill  out  1  replace slot1 with NOP at the ID/EX input
halt_ack  out  1  pipeline drained and halted
stall_cnt  out  CNT_W  cycles stalled (load-use, split, drain and halted)
flush_cnt  out  CNT_W  mispredict flushes

Behaviour:
- Reset is asynchronous and active-low: state=RUN, drain counter=0, halt_ack=0, both counters=0.
- Control outputs are combinational from state and current inputs (same-cycle effect on the pipe registers). With reset low, all control outputs are 0.
- States: RUN, SPLIT, DRAIN, HALTED.
- Priority in every state: br_mispredict > lu_hazard > pair_conflict > halt_req.
- RUN:
  - br_mispredict: ifid_flush=1, idex_flush=1, pc_hold=0; flush_cnt+1; hazards ignored; stay RUN.
  - lu_hazard: pc_hold=1, ifid_hold=1, idex_flush=1; stall_cnt+1; stay RUN.
  - pair_conflict: pc_hold=1, ifid_hold=1, slot1_kill=1 (slot0 issues alone); stall_cnt+1; go to SPLIT.
  - halt_req: pc_hold=1, ifid_hold=1, idex_flush=1; load drain counter with DRAIN_CYCLES-1; go to DRAIN.
- SPLIT:
  - Default: slot0_kill=1 so slot1 issues alone; PC and IF/ID advance; go to RUN.
  - br_mispredict: flush exactly as in RUN; go to RUN.
  - lu_hazard on slot1: hold and bubble as in RUN; stay SPLIT.
  - halt_req: not sampled in SPLIT; it is taken in RUN afterwards.
- DRAIN:
  - pc_hold=1, ifid_hold=1, idex_flush=1 every cycle; stall_cnt+1; counter decrements.
  - At counter=0: go to HALTED and set halt_ack to 1, registered (visible the next cycle).
  - br_mispredict: pc_hold=0, ifid_flush=1, idex_flush=1; flush_cnt+1; reload counter with DRAIN_CYCLES-1.
  - halt_req dropping during DRAIN: return to RUN next cycle; halt_ack stays 0.
- HALTED:
  - pc_hold=1, ifid_hold=1, idex_flush=1; halt_ack=1; stall_cnt+1.
  - halt_req=0: next state RUN; halt_ack clears on that same edge.
- Control-output rules:
  - Flush has priority over hold; ifid_hold and ifid_flush are never both 1.
  - slot0_kill and slot1_kill are never both 1.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle.
- Reset asserted mid-operation: immediate return to RUN with all outputs and counters cleared.

Decomposition:
- Shared pipeline package holds:
  - the state encoding (RUN=2'd0, SPLIT=2'd1, DRAIN=2'd2, HALTED=2'd3);
  - a control-bundle struct {pc_hold, ifid_hold, ifid_flush, idex_flush, slot0_kill, slot1_kill};
  - the DRAIN_CYCLES default.
- One sub-module, sat_counter (parameterised width, inc, clr, asynchronous active-low reset), instantiated twice.

Test Plan:
- Reset released, all inputs 0 for 5 cycles -> all controls 0, halt_ack=0, stall_cnt=0, flush_cnt=0.
- lu_hazard=1 for 1 cycle in RUN -> that cycle pc_hold=ifid_hold=idex_flush=1; stall_cnt=1; next cycle all 0.
- pair_conflict=1 for 1 cycle -> cycle N: slot1_kill=1, pc_hold=1, ifid_hold=1; cycle N+1: slot0_kill=1, no hold; cycle N+2: RUN, all 0.
- Two lu_hazard cycles together with br_mispredict in the first -> first cycle flushes only (ifid_flush=idex_flush=1, pc_hold=0), flush_cnt=1; second cycle stalls, stall_cnt=1.
- halt_req held with DRAIN_CYCLES=3 -> 3 drain cycles with holds and bubbles, halt_ack=1 from cycle 4; drop halt_req -> next cycle RUN, halt_ack=0, stall_cnt counts every held cycle.
- br_mispredict in the 2nd drain cycle -> pc_hold=0 and both flushes that cycle, drain restarts, halt_ack delayed by 2 cycles; then reset pulsed low while HALTED -> all outputs 0 asynchronously, state RUN.
